// File: rtl/memarb.sv
// rtl/memarb.sv - fetch/data single-port memory arbiter with one-cycle read return
// Optional fetch anti-starvation counter enabled by defining MEMARB_FAIR_EN.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module memarb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  iw_if_req,
  input  logic [`SIZE_ADDR-1:0] iw_if_addr,
  output logic                  ow_if_gnt,
  output logic                  ow_if_rvalid,
  output logic [`SIZE_DATA-1:0] ow_if_rdata,
  output logic                  ow_if_stall,
  input  logic                  iw_ma_req,
  input  logic                  iw_ma_we,
  input  logic [`SIZE_ADDR-1:0] iw_ma_addr,
  input  logic [`SIZE_DATA-1:0] iw_ma_wdata,
  output logic                  ow_ma_gnt,
  output logic                  ow_ma_rvalid,
  output logic [`SIZE_DATA-1:0] ow_ma_rdata,
  output logic                  ow_mem_we,
  output logic [`SIZE_ADDR-1:0] ow_mem_addr,
  output logic [`SIZE_DATA-1:0] ow_mem_wdata,
  input  logic [`SIZE_DATA-1:0] iw_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_MA = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   force_if;

`ifdef MEMARB_FAIR_EN
  logic [3:0] starve_q, starve_d;

  // Once data has won STARVE_MAX times in a row against a waiting fetch, fetch wins once.
  assign force_if = iw_if_req && iw_ma_req && (starve_q == 4'(STARVE_MAX));

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) starve_q <= 4'd0;
    else        starve_q <= starve_d;
  end

  always_comb begin
    starve_d = starve_q;
    if (!iw_if_req || ow_if_gnt) starve_d = 4'd0;
    else if (ow_ma_gnt)          starve_d = starve_q + 4'd1;
  end
`else
  assign force_if = 1'b0;
`endif

  assign ow_ma_gnt   = !iw_rst && iw_ma_req && !force_if;
  assign ow_if_gnt   = !iw_rst && iw_if_req && !ow_ma_gnt;
  assign ow_if_stall = !iw_rst && iw_if_req && !ow_if_gnt;

  assign ow_mem_we    = iw_ma_we && ow_ma_gnt;
  assign ow_mem_addr  = ow_ma_gnt ? iw_ma_addr : (ow_if_gnt ? iw_if_addr : '0);
  assign ow_mem_wdata = ow_mem_we ? iw_ma_wdata : '0;

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // State tracks which requester owns the read data returning next cycle.
  always_comb begin
    state_d = IDLE;
    if (ow_if_gnt)                   state_d = RD_IF;
    else if (ow_ma_gnt && !iw_ma_we) state_d = RD_MA;
  end

  always_comb begin
    ow_if_rvalid = 1'b0;
    ow_ma_rvalid = 1'b0;
    ow_if_rdata  = '0;
    ow_ma_rdata  = '0;
    case (state_q)
      RD_IF: begin
        ow_if_rvalid = 1'b1;
        ow_if_rdata  = iw_mem_rdata;
      end
      RD_MA: begin
        ow_ma_rvalid = 1'b1;
        ow_ma_rdata  = iw_mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memarb.sv
// tb/tb_memarb.sv - directed self-checking bench for memarb with a behavioural single-port memory
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module tb_memarb;
  logic                  iw_clk = 1'b0;
  logic                  iw_rst;
  logic                  iw_if_req;
  logic [`SIZE_ADDR-1:0] iw_if_addr;
  logic                  ow_if_gnt, ow_if_rvalid, ow_if_stall;
  logic [`SIZE_DATA-1:0] ow_if_rdata;
  logic                  iw_ma_req, iw_ma_we;
  logic [`SIZE_ADDR-1:0] iw_ma_addr;
  logic [`SIZE_DATA-1:0] iw_ma_wdata;
  logic                  ow_ma_gnt, ow_ma_rvalid;
  logic [`SIZE_DATA-1:0] ow_ma_rdata;
  logic                  ow_mem_we;
  logic [`SIZE_ADDR-1:0] ow_mem_addr;
  logic [`SIZE_DATA-1:0] ow_mem_wdata;
  logic [`SIZE_DATA-1:0] iw_mem_rdata;

  int n_total = 0;
  int n_bad   = 0;
  int n_fetch;
  bit fair;

  logic [`SIZE_DATA-1:0] mem [0:255];
  logic [255:0]          written;

  memarb #(.STARVE_MAX(4)) dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst),
    .iw_if_req(iw_if_req), .iw_if_addr(iw_if_addr),
    .ow_if_gnt(ow_if_gnt), .ow_if_rvalid(ow_if_rvalid), .ow_if_rdata(ow_if_rdata),
    .ow_if_stall(ow_if_stall),
    .iw_ma_req(iw_ma_req), .iw_ma_we(iw_ma_we), .iw_ma_addr(iw_ma_addr),
    .iw_ma_wdata(iw_ma_wdata),
    .ow_ma_gnt(ow_ma_gnt), .ow_ma_rvalid(ow_ma_rvalid), .ow_ma_rdata(ow_ma_rdata),
    .ow_mem_we(ow_mem_we), .ow_mem_addr(ow_mem_addr), .ow_mem_wdata(ow_mem_wdata),
    .iw_mem_rdata(iw_mem_rdata)
  );

  always #5 iw_clk = ~iw_clk;

  function automatic logic [`SIZE_DATA-1:0] memval(input int a);
    return 32'hC0DE_0000 + 32'(a * 7);
  endfunction

  // Unwritten locations read back a fixed address-derived pattern.
  always @(posedge iw_clk) begin
    if (iw_rst) written <= '0;
    else if (ow_mem_we) begin
      mem[ow_mem_addr[7:0]]     <= ow_mem_wdata;
      written[ow_mem_addr[7:0]] <= 1'b1;
    end
    iw_mem_rdata <= written[ow_mem_addr[7:0]] ? mem[ow_mem_addr[7:0]] : memval(int'(ow_mem_addr[7:0]));
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iw_clk);
    #1;
  endtask

  task automatic idle_inputs();
    iw_if_req = 0; iw_if_addr = '0;
    iw_ma_req = 0; iw_ma_we = 0; iw_ma_addr = '0; iw_ma_wdata = '0;
  endtask

  initial begin
`ifdef MEMARB_FAIR_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif
    iw_rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge iw_clk);
    @(negedge iw_clk);
    check("rst_if_gnt", 32'(ow_if_gnt), 0);
    check("rst_ma_gnt", 32'(ow_ma_gnt), 0);
    check("rst_rvalid", {30'd0, ow_if_rvalid, ow_ma_rvalid}, 0);
    check("rst_rdata", ow_if_rdata | ow_ma_rdata, 0);
    check("rst_mem_we", 32'(ow_mem_we), 0);
    tick();
    iw_rst = 1'b0;

    // fetch-only stream 0x10, 0x11, 0x12
    iw_if_req = 1; iw_if_addr = 16'h10;
    @(negedge iw_clk);
    check("if0_gnt", 32'(ow_if_gnt), 1);
    check("if0_addr", 32'(ow_mem_addr), 32'h10);
    check("if0_rvalid", 32'(ow_if_rvalid), 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i < 3) iw_if_addr = 16'(16'h10 + i);
      else       iw_if_req = 0;
      @(negedge iw_clk);
      check($sformatf("if%0d_gnt", i), 32'(ow_if_gnt), (i < 3) ? 1 : 0);
      check($sformatf("if%0d_rvalid", i), 32'(ow_if_rvalid), 1);
      check($sformatf("if%0d_rdata", i), ow_if_rdata, memval(16'h10 + i - 1));
    end

    // both requesting: data read wins, fetch stalls
    tick();
    iw_if_req = 1; iw_if_addr = 16'h50;
    iw_ma_req = 1; iw_ma_we = 0; iw_ma_addr = 16'h40;
    @(negedge iw_clk);
    check("both_ma_gnt", 32'(ow_ma_gnt), 1);
    check("both_if_gnt", 32'(ow_if_gnt), 0);
    check("both_stall", 32'(ow_if_stall), 1);
    check("both_addr", 32'(ow_mem_addr), 32'h40);
    tick();
    idle_inputs();
    @(negedge iw_clk);
    check("ma_rvalid", 32'(ow_ma_rvalid), 1);
    check("ma_rdata", ow_ma_rdata, memval(16'h40));
    check("ma_if_rvalid", 32'(ow_if_rvalid), 0);
    check("ma_if_rdata", ow_if_rdata, 0);

    // data write then read-back
    tick();
    iw_ma_req = 1; iw_ma_we = 1; iw_ma_addr = 16'h20; iw_ma_wdata = 32'hAB;
    @(negedge iw_clk);
    check("wr_mem_we", 32'(ow_mem_we), 1);
    check("wr_addr", 32'(ow_mem_addr), 32'h20);
    check("wr_wdata", ow_mem_wdata, 32'hAB);
    tick();
    iw_ma_we = 0; iw_ma_wdata = '0;
    @(negedge iw_clk);
    check("wr_no_rvalid", {30'd0, ow_if_rvalid, ow_ma_rvalid}, 0);
    check("rd20_mem_we", 32'(ow_mem_we), 0);
    tick();
    idle_inputs();
    @(negedge iw_clk);
    check("rd20_rvalid", 32'(ow_ma_rvalid), 1);
    check("rd20_rdata", ow_ma_rdata, 32'hAB);
    check("idle_gnts", {30'd0, ow_if_gnt, ow_ma_gnt}, 0);

    // continuous contention: starvation relief only in fair builds
    n_fetch = 0;
    tick();
    iw_if_req = 1; iw_if_addr = 16'h60;
    iw_ma_req = 1; iw_ma_addr = 16'h41;
    for (int k = 0; k < 20; k++) begin
      @(negedge iw_clk);
      check($sformatf("starve%0d_if", k), 32'(ow_if_gnt), (fair && (k % 5 == 4)) ? 1 : 0);
      check($sformatf("starve%0d_ma", k), 32'(ow_ma_gnt), (fair && (k % 5 == 4)) ? 0 : 1);
      if (ow_if_gnt) n_fetch++;
      tick();
    end
    check("starve_fetch_count", 32'(n_fetch), fair ? 4 : 0);

    // reset with a fetch read outstanding
    idle_inputs();
    tick();
    iw_if_req = 1; iw_if_addr = 16'h33;
    @(negedge iw_clk);
    check("rst_pre_gnt", 32'(ow_if_gnt), 1);
    tick();
    iw_rst = 1; idle_inputs();
    @(negedge iw_clk);
    check("rstrd_if_rvalid", 32'(ow_if_rvalid), 0);
    check("rstrd_if_rdata", ow_if_rdata, 0);
    check("rstrd_gnts", {30'd0, ow_if_gnt, ow_ma_gnt}, 0);
    check("rstrd_mem", {31'd0, ow_mem_we} | 32'(ow_mem_addr) | ow_mem_wdata, 0);
    tick();
    iw_rst = 0;
    @(negedge iw_clk);
    check("post_if_rvalid", 32'(ow_if_rvalid), 0);
    check("post_ma_rvalid", 32'(ow_ma_rvalid), 0);
    check("post_rdata", ow_if_rdata | ow_ma_rdata, 0);
    check("post_stall", 32'(ow_if_stall), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/memarb.md
MEMARB -- requirements
Module: memarb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive data grants while fetch is waiting (1..15).
REQ-002 SHALL have port iw_clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port iw_rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port iw_if_req  in  1  fetch-stage read request.
REQ-005 SHALL have port iw_if_addr  in  `SIZE_ADDR  fetch address.
REQ-006 SHALL have port ow_if_gnt  out  1  fetch request accepted this cycle.
REQ-007 SHALL have port ow_if_rvalid  out  1  fetch read data valid.
REQ-008 SHALL have port ow_if_rdata  out  `SIZE_DATA  fetch read data.
REQ-009 SHALL have port iw_ma_req  in  1  memory-access-stage request.
REQ-010 SHALL have port iw_ma_we  in  1  1 = write, 0 = read.
REQ-011 SHALL have port iw_ma_addr  in  `SIZE_ADDR  data address.
REQ-012 SHALL have port iw_ma_wdata  in  `SIZE_DATA  write data.
REQ-013 SHALL have port ow_ma_gnt  out  1  data request accepted this cycle.
REQ-014 SHALL have port ow_ma_rvalid  out  1  data read data valid.
REQ-015 SHALL have port ow_ma_rdata  out  `SIZE_DATA  data read data.
REQ-016 SHALL have ports ow_mem_we (1), ow_mem_addr (`SIZE_ADDR), ow_mem_wdata (`SIZE_DATA) out, iw_mem_rdata (`SIZE_DATA) in: single-port memory, registered read data one cycle after address.
REQ-017 SHALL have port ow_if_stall  out  1  high when iw_if_req high and ow_if_gnt low.

Function
REQ-018 Grants combinational from current requests and registered state; at most one of ow_if_gnt/ow_ma_gnt high per cycle.
REQ-019 Default priority: data over fetch (older instruction); granted when iw_ma_req high, unless REQ-030 forces fetch.
REQ-020 Fetch granted when iw_if_req high and data not granted.
REQ-021 Memory port driven from granted requester; ow_mem_we = iw_ma_we & ow_ma_gnt; no grant -> ow_mem_we 0, ow_mem_addr/ow_mem_wdata 0.
REQ-022 Owner FSM, states IDLE, RD_IF, RD_MA: next state RD_IF on fetch grant, RD_MA on data read grant, IDLE otherwise (including data writes).
REQ-023 Read latency exactly 1 cycle: state RD_IF -> ow_if_rvalid 1, ow_if_rdata = iw_mem_rdata; state RD_MA -> ow_ma_rvalid 1, ow_ma_rdata = iw_mem_rdata.
REQ-024 Non-owner rdata output SHALL be 0; rvalid never asserted in IDLE.
REQ-025 Back-to-back grants permitted every cycle; a new grant in the cycle rvalid is delivered is legal (full throughput).
REQ-026 Write completes in grant cycle; no rvalid produced.
REQ-027 Requests SHALL hold address/data stable until granted; memarb does not buffer requests.
REQ-028 Neither request -> state IDLE, all grants 0.

Reset
REQ-029 While iw_rst high: FSM IDLE, starvation counter 0, grants 0, rvalid 0, rdata 0, ow_mem_we 0; reset asserted with a read outstanding discards it (no rvalid after deassert).

Configuration
REQ-030 Macro MEMARB_FAIR_EN defined: 4-bit counter increments on each data grant while iw_if_req high, clears on fetch grant or when iw_if_req low; counter == STARVE_MAX with both requests -> fetch granted, data stalled one cycle, counter cleared.
REQ-031 MEMARB_FAIR_EN undefined: no counter logic; pure fixed data priority, fetch may starve indefinitely.

Verification
REQ-032 Fetch only, addr 0x10,0x11,0x12 consecutive cycles -> if_gnt 1 each cycle, if_rvalid 1 one cycle later each, rdata matches mem contents.
REQ-033 Both requesting, ma_we 0 addr 0x40 -> ma_gnt 1, if_gnt 0, if_stall 1; next cycle ma_rvalid 1 with mem[0x40], if_rvalid 0.
REQ-034 Data write addr 0x20 data 0xAB -> mem_we 1 that cycle, no rvalid; subsequent data read of 0x20 returns 0xAB.
REQ-035 MEMARB_FAIR_EN, STARVE_MAX 4, both requesting continuously -> pattern 4 data grants, 1 fetch grant, repeating; without macro -> 0 fetch grants.
REQ-036 Fetch read granted, iw_rst pulsed next cycle -> if_rvalid 0 during and after reset, FSM IDLE, all outputs 0.
